readrc_stream: RTL and testbench

Sequential loader for a Toeplitz seed: the first row (N bits) and first column (L bits).
- Reads the seed from a BS-wide synchronous memory, one word per cycle, instead of from hard-wired constants.
- Selects one of NSEED stored seeds at run time.
- Presents rrow0/col0 to the Toeplitz hashing datapath, with a start/busy/done/valid handshake.

---
 rtl/readrc_pkg.sv | 32 +++
 rtl/readrc_tagpipe.sv | 52 +++++
 rtl/readrc_stream.sv | 178 +++++++++++++++++
 tb/tb_readrc_stream.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/readrc_pkg.sv
// Shared types and helpers for the Toeplitz seed loader.
// Contents:
//   state_t         loader FSM states
//   words_per_seed  memory words per stored seed (first row + first column)
//   clog2_min1      ceil(log2(v)), never less than 1 bit
//   addr_width      memory word address width for NSEED seeds of W words
//   params_ok       legality of the parameter set, evaluated at elaboration
package readrc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int words_per_seed(input int n, input int l, input int bs);
    return (n + l) / bs;
  endfunction

  function automatic int clog2_min1(input int v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

  function automatic int addr_width(input int nseed, input int w);
    return clog2_min1(nseed * w);
  endfunction

  function automatic bit params_ok(input int n, input int l, input int bs, input int memlat);
    return (bs > 0) && (n % bs == 0) && (l % bs == 0) && (memlat >= 1);
  endfunction

endpackage

// File: rtl/readrc_tagpipe.sv
// Tag pipeline that tracks outstanding memory reads.
// Each read strobe pushes {vld, idx}; the tag leaves the last stage exactly
// DEPTH cycles later, in the cycle whose rising edge captures the read data.
// Ports:
//   clk, reset_n      clock, asynchronous active-low clear
//   in_vld, in_idx    tag of the read strobed in the current cycle
//   out_vld, out_idx  tag whose data is on mem_rdata this cycle
//   empty             nothing in flight beyond the tag leaving this cycle,
//                     so the seed is complete after this edge
module readrc_tagpipe #(
  parameter int DEPTH = 1,
  parameter int IW    = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_vld,
  input  logic [IW-1:0] in_idx,
  output logic          out_vld,
  output logic [IW-1:0] out_idx,
  output logic          empty
);

  logic [DEPTH-1:0]         vld_q;
  logic [DEPTH-1:0][IW-1:0] idx_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q[0] <= in_vld;
      idx_q[0] <= in_idx;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_idx = idx_q[DEPTH-1];

  // The last stage is deliberately excluded: its data lands at this edge,
  // which lets done/valid rise in the very next cycle.
  always_comb begin
    empty = !in_vld;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (vld_q[i]) empty = 1'b0;
    end
  end

endmodule

// File: rtl/readrc_stream.sv
// Sequential loader for a Toeplitz seed (first row rrow0, first column col0).
// Reads W = (N+L)/BS words of one of NSEED seeds from a synchronous memory,
// one word per cycle, and presents the assembled seed with a valid flag.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   start          load request, sampled only in IDLE
//   seed_sel       seed index, sampled with start
//   busy           load in progress
//   done           one-cycle pulse at load completion (valid rises with it)
//   err            one-cycle pulse when start carries an out-of-range seed_sel
//   valid          rrow0/col0 hold a complete seed
//   mem_rd         registered memory read strobe
//   mem_addr       registered memory word address
//   mem_rdata      read data, MEMLAT cycles after the strobe
//   rrow0, col0    first row / first column
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last loaded seed
// FETCH | issuing one read per cycle, words base .. base+W-1
// DRAIN | reads issued, waiting for the last data to land
module readrc_stream
  import readrc_pkg::*;
#(
  parameter  int BS     = 64,
  parameter  int N      = 256,
  parameter  int L      = 128,
  parameter  int NSEED  = 4,
  parameter  int MEMLAT = 1,
  localparam int W      = words_per_seed(N, L, BS),
  localparam int AW     = addr_width(NSEED, W),
  localparam int SW     = clog2_min1(NSEED)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [SW-1:0] seed_sel,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          valid,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [BS-1:0] mem_rdata,
  output logic [N-1:0]  rrow0,
  output logic [L-1:0]  col0
);

  localparam int          CW      = clog2_min1(W);
  localparam logic [31:0] NSEED_U = NSEED;

  if (!params_ok(N, L, BS, MEMLAT)) begin : g_bad_params
    $error("readrc_stream: N and L must be multiples of BS and MEMLAT must be >= 1");
  end

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   base_q, base_d;
  logic            mem_rd_q, mem_rd_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            valid_q, valid_d;
  logic [N+L-1:0]  seed_q;

  logic            sel_ok;
  logic [AW-1:0]   sel_base;
  logic            tag_vld;
  logic [CW-1:0]   tag_idx;
  logic            pipe_empty;

  assign sel_ok   = (32'(seed_sel) < NSEED_U);
  // Largest product is (NSEED-1)*W, which always fits in AW bits.
  assign sel_base = AW'(seed_sel) * AW'(W);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      done_q     <= done_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state and next-output logic. mem_rd/mem_addr are computed one cycle
  // ahead so that the strobe and address leave the block registered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    valid_d    = valid_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (sel_ok) begin
            state_d    = FETCH;
            base_d     = sel_base;
            cnt_d      = '0;
            mem_rd_d   = 1'b1;
            mem_addr_d = sel_base;
            valid_d    = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (cnt_q == CW'(W - 1)) begin
          state_d = DRAIN;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          mem_rd_d   = 1'b1;
          mem_addr_d = base_q + AW'(cnt_d);
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // cnt_q is the word index of the read strobed in the current cycle.
  readrc_tagpipe #(
    .DEPTH (MEMLAT),
    .IW    (CW)
  ) u_tagpipe (
    .clk     (clk),
    .reset_n (reset_n),
    .in_vld  (mem_rd_q),
    .in_idx  (cnt_q),
    .out_vld (tag_vld),
    .out_idx (tag_idx),
    .empty   (pipe_empty)
  );

  // Row words and column words are stored contiguously, so word k of the
  // seed always lands in seed_q[k*BS +: BS].
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seed_q <= '0;
    end else if (tag_vld) begin
      for (int k = 0; k < W; k++) begin
        if (tag_idx == CW'(k)) seed_q[k*BS +: BS] <= mem_rdata;
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign valid    = valid_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign rrow0    = seed_q[N-1:0];
  assign col0     = seed_q[N+L-1:N];

endmodule

// File: tb/tb_readrc_stream.sv
// Self-checking bench for readrc_stream.
// Three instances: defaults (u_dut0), MEMLAT=3 (u_dut1), NSEED=3 (u_dut2).
// Expected seeds are pushed to a per-instance queue when a load is started
// and popped/compared when that instance pulses done.
module tb_readrc_stream;

  localparam int BS  = 64;
  localparam int N   = 256;
  localparam int L   = 128;
  localparam int W   = 6;
  localparam int AW  = 5;
  localparam int CKW = N + L;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int ndone0 = 0;

  logic            start0, start1, start2;
  logic [1:0]      sel0, sel1, sel2;
  logic            busy0, busy1, busy2;
  logic            done0, done1, done2;
  logic            err0, err1, err2;
  logic            valid0, valid1, valid2;
  logic            rd0, rd1, rd2;
  logic [AW-1:0]   addr0, addr1, addr2;
  logic [BS-1:0]   rdata0, rdata1, rdata2;
  logic [BS-1:0]   p1_1, p1_2;
  logic [N-1:0]    row0, row1, row2;
  logic [L-1:0]    col_0, col_1, col_2;

  logic [CKW-1:0]  sb0[$];
  logic [CKW-1:0]  sb1[$];
  logic [CKW-1:0]  sb2[$];

  readrc_stream u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .seed_sel(sel0),
    .busy(busy0), .done(done0), .err(err0), .valid(valid0),
    .mem_rd(rd0), .mem_addr(addr0), .mem_rdata(rdata0),
    .rrow0(row0), .col0(col_0)
  );

  readrc_stream #(.MEMLAT(3)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .seed_sel(sel1),
    .busy(busy1), .done(done1), .err(err1), .valid(valid1),
    .mem_rd(rd1), .mem_addr(addr1), .mem_rdata(rdata1),
    .rrow0(row1), .col0(col_1)
  );

  readrc_stream #(.NSEED(3)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .seed_sel(sel2),
    .busy(busy2), .done(done2), .err(err2), .valid(valid2),
    .mem_rd(rd2), .mem_addr(addr2), .mem_rdata(rdata2),
    .rrow0(row2), .col0(col_2)
  );

  function automatic logic [BS-1:0] mem_word(input int a);
    return {32'hA5A5_0000 | 32'(a), 32'h5A5A_0000 | 32'(a)};
  endfunction

  function automatic logic [CKW-1:0] exp_seed(input int sel);
    logic [CKW-1:0] s;
    s = '0;
    for (int k = 0; k < W; k++) s[k*BS +: BS] = mem_word(sel * W + k);
    return s;
  endfunction

  // Memory models; non-strobed cycles return a poison word.
  always @(posedge clk) begin
    rdata0 <= rd0 ? mem_word(32'(addr0)) : 64'hDEAD_BEEF_DEAD_BEEF;
    rdata2 <= rd2 ? mem_word(32'(addr2)) : 64'hDEAD_BEEF_DEAD_BEEF;
    p1_1   <= rd1 ? mem_word(32'(addr1)) : 64'hDEAD_BEEF_DEAD_BEEF;
    p1_2   <= p1_1;
    rdata1 <= p1_2;
  end

  task automatic check_val(input string tag, input logic [CKW-1:0] obs, input logic [CKW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors.
  always @(negedge clk) begin
    logic [CKW-1:0] e;
    if (done0) begin
      ndone0++;
      check_val("d0_sb_pending", CKW'(sb0.size() != 0), CKW'(1));
      if (sb0.size() != 0) begin
        e = sb0.pop_front();
        check_val("d0_rrow0", CKW'(row0), CKW'(e[N-1:0]));
        check_val("d0_col0", CKW'(col_0), CKW'(e[CKW-1:N]));
      end
    end
    if (done1) begin
      check_val("d1_sb_pending", CKW'(sb1.size() != 0), CKW'(1));
      if (sb1.size() != 0) begin
        e = sb1.pop_front();
        check_val("d1_rrow0", CKW'(row1), CKW'(e[N-1:0]));
        check_val("d1_col0", CKW'(col_1), CKW'(e[CKW-1:N]));
      end
    end
    if (done2) begin
      check_val("d2_sb_pending", CKW'(sb2.size() != 0), CKW'(1));
      if (sb2.size() != 0) begin
        e = sb2.pop_front();
        check_val("d2_rrow0", CKW'(row2), CKW'(e[N-1:0]));
        check_val("d2_col0", CKW'(col_2), CKW'(e[CKW-1:N]));
      end
    end
  end

  // Drives start at the current negedge (start in a done cycle chains loads)
  // and checks cycles 1..W+2 of a MEMLAT=1 load on u_dut0.
  task automatic run_load0(input int sel, input bit inject);
    start0 = 1'b1;
    sel0   = 2'(sel);
    sb0.push_back(exp_seed(sel));
    for (int c = 1; c <= W + 2; c++) begin
      @(negedge clk);
      if (c == 1) start0 = 1'b0;
      check_val("d0_mem_rd", CKW'(rd0), CKW'(c <= W));
      if (c <= W) check_val("d0_mem_addr", CKW'(addr0), CKW'(sel * W + c - 1));
      check_val("d0_busy", CKW'(busy0), CKW'(c <= W + 1));
      check_val("d0_done", CKW'(done0), CKW'(c == W + 2));
      check_val("d0_valid", CKW'(valid0), CKW'(c == W + 2));
      if (inject && c == 3) begin
        start0 = 1'b1;
        sel0   = 2'd1;
      end
      if (inject && c == 4) start0 = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CKW-1:0] e2;
    int             saved;
    int             guard;

    reset_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    sel0 = '0; sel1 = '0; sel2 = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", CKW'(busy0), CKW'(0));
    check_val("rst_valid", CKW'(valid0), CKW'(0));
    check_val("rst_mem_rd", CKW'(rd0), CKW'(0));
    check_val("rst_mem_addr", CKW'(addr0), CKW'(0));
    check_val("rst_seed", CKW'({col_0, row0}), CKW'(0));
    reset_n = 1'b1;
    @(negedge clk);

    run_load0(0, 1'b0);
    repeat (2) @(negedge clk);
    check_val("d0_one_done", CKW'(ndone0), CKW'(1));

    run_load0(2, 1'b0);
    @(negedge clk);

    // Start while busy must be ignored; then chain a load in the done cycle.
    run_load0(0, 1'b1);
    run_load0(1, 1'b0);
    repeat (2) @(negedge clk);
    check_val("d0_done_count", CKW'(ndone0), CKW'(4));

    // Asynchronous reset in cycle 4 of a load.
    start0 = 1'b1;
    sel0   = 2'd0;
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    saved = ndone0;
    #2 reset_n = 1'b0;
    #1;
    check_val("ar_busy", CKW'(busy0), CKW'(0));
    check_val("ar_done", CKW'(done0), CKW'(0));
    check_val("ar_valid", CKW'(valid0), CKW'(0));
    check_val("ar_mem_rd", CKW'(rd0), CKW'(0));
    check_val("ar_mem_addr", CKW'(addr0), CKW'(0));
    check_val("ar_rrow0", CKW'(row0), CKW'(0));
    check_val("ar_col0", CKW'(col_0), CKW'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check_val("ar_no_done", CKW'(ndone0), CKW'(saved));
    run_load0(3, 1'b0);
    @(negedge clk);

    // MEMLAT = 3, seed 1.
    start1 = 1'b1;
    sel1   = 2'd1;
    sb1.push_back(exp_seed(1));
    for (int c = 1; c <= W + 4; c++) begin
      @(negedge clk);
      if (c == 1) start1 = 1'b0;
      check_val("d1_mem_rd", CKW'(rd1), CKW'(c <= W));
      if (c <= W) check_val("d1_mem_addr", CKW'(addr1), CKW'(W + c - 1));
      check_val("d1_busy", CKW'(busy1), CKW'(c <= W + 3));
      check_val("d1_done", CKW'(done1), CKW'(c == W + 4));
      check_val("d1_valid", CKW'(valid1), CKW'(c == W + 4));
    end
    @(negedge clk);

    // NSEED = 3: load seed 2, then an out-of-range select.
    e2     = exp_seed(2);
    start2 = 1'b1;
    sel2   = 2'd2;
    sb2.push_back(e2);
    @(negedge clk);
    start2 = 1'b0;
    guard  = 0;
    while (!done2 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_val("d2_done_seen", CKW'(done2), CKW'(1));
    @(negedge clk);
    start2 = 1'b1;
    sel2   = 2'd3;
    @(negedge clk);
    start2 = 1'b0;
    check_val("d2_err", CKW'(err2), CKW'(1));
    check_val("d2_err_mem_rd", CKW'(rd2), CKW'(0));
    check_val("d2_err_busy", CKW'(busy2), CKW'(0));
    check_val("d2_err_valid", CKW'(valid2), CKW'(1));
    check_val("d2_err_rrow0", CKW'(row2), CKW'(e2[N-1:0]));
    check_val("d2_err_col0", CKW'(col_2), CKW'(e2[CKW-1:N]));
    @(negedge clk);
    check_val("d2_err_pulse", CKW'(err2), CKW'(0));
    check_val("d2_err_mem_rd2", CKW'(rd2), CKW'(0));
    check_val("d2_hold_valid", CKW'(valid2), CKW'(1));
    check_val("d2_hold_rrow0", CKW'(row2), CKW'(e2[N-1:0]));
    repeat (2) @(negedge clk);

    check_val("sb0_drained", CKW'(sb0.size()), CKW'(0));
    check_val("sb1_drained", CKW'(sb1.size()), CKW'(0));
    check_val("sb2_drained", CKW'(sb2.size()), CKW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
